// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and defaults.
// Defaults match those used by instruction_memory and decode.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 32;
  localparam int COUNT_W_DEF = 16;

  typedef enum logic [1:0] {
    PC_RESET,
    PC_LOAD,
    PC_HOLD,
    PC_INC
  } pc_op_e;

  // Reset beats redirect beats stall.
  function automatic pc_op_e pc_sel(
    input logic reset,
    input logic redirect,
    input logic hold
  );
    if (reset)         return PC_RESET;
    else if (redirect) return PC_LOAD;
    else if (hold)     return PC_HOLD;
    else               return PC_INC;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Next-fetch PC register.
// Reset, redirect load, stall hold or increment.
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  pc_op_e            op,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] fetch_pc
);

  always_ff @(posedge clock) begin
    unique case (op)
      PC_RESET: fetch_pc <= RESET_PC;
      PC_LOAD:  fetch_pc <= redirect_pc;
      PC_HOLD:  fetch_pc <= fetch_pc;
      PC_INC:   fetch_pc <= fetch_pc + 1'b1;
      default:  fetch_pc <= fetch_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives imem, hands words to decode.
// Supports back-pressure, redirect squash and an accept counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [DATA_W-1:0]  imem_data,
  output logic               instr_valid,
  output logic [DATA_W-1:0]  instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               decode_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [COUNT_W-1:0] fetch_count
);

  logic [ADDR_W-1:0]  fetch_pc;
  logic               resp_valid;
  logic [ADDR_W-1:0]  resp_pc;
  logic [COUNT_W-1:0] count;
  logic               stall;
  pc_op_e             pc_op;

  assign stall = resp_valid & ~decode_ready & ~redirect_valid;
  assign pc_op = pc_sel(reset, redirect_valid, stall);

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock       (clock),
    .op          (pc_op),
    .redirect_pc (redirect_pc),
    .fetch_pc    (fetch_pc)
  );

  // Re-read the held word so imem_data stays put during a stall.
  assign imem_addr   = stall ? resp_pc : fetch_pc;
  assign instr_valid = resp_valid & ~redirect_valid;
  assign instr       = imem_data;
  assign instr_pc    = resp_pc;
  assign fetch_count = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_pc    <= '0;
      count      <= '0;
    end else begin
      if (instr_valid && decode_ready)
        count <= count + 1'b1;
      if (redirect_valid) begin
        resp_valid <= 1'b0;
      end else if (!stall) begin
        resp_valid <= 1'b1;
        resp_pc    <= fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Two instances: default params, and RESET_PC=FE / COUNT_W=4.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        decode_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [15:0] fetch_count;

  logic        reset2;
  logic [7:0]  imem_addr2;
  logic [31:0] imem_data2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [7:0]  instr_pc2;
  logic [3:0]  fetch_count2;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  fetch_unit u_dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .decode_ready   (decode_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_count    (fetch_count)
  );

  fetch_unit #(
    .RESET_PC (8'hFE),
    .COUNT_W  (4)
  ) u_wrap (
    .clock          (clock),
    .reset          (reset2),
    .imem_addr      (imem_addr2),
    .imem_data      (imem_data2),
    .instr_valid    (instr_valid2),
    .instr          (instr2),
    .instr_pc       (instr_pc2),
    .decode_ready   (1'b1),
    .redirect_valid (1'b0),
    .redirect_pc    (8'h00),
    .fetch_count    (fetch_count2)
  );

  always @(posedge clock) begin
    imem_data  <= 32'hA000_0000 + {24'h0, imem_addr};
    imem_data2 <= 32'hA000_0000 + {24'h0, imem_addr2};
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [7:0] pc,
                         input logic [15:0] cnt);
    chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, v});
    if (v) begin
      chk({tag, ".pc"}, {24'h0, instr_pc}, {24'h0, pc});
      chk({tag, ".instr"}, instr, 32'hA000_0000 + {24'h0, pc});
    end
    chk({tag, ".count"}, {16'h0, fetch_count}, {16'h0, cnt});
  endtask

  initial begin
    reset = 1'b1;
    reset2 = 1'b1;
    decode_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    tick;
    tick;
    // T1: reset release and streaming
    reset = 1'b0;
    #1;
    chk_out("t1_rst", 1'b0, 8'h00, 16'd0);
    chk("t1_addr0", {24'h0, imem_addr}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick;
      #1;
      chk_out($sformatf("t1_pc%0d", i), 1'b1, 8'(i), 16'(i));
    end
    // T2: stall on pc 5 for 3 cycles
    for (int i = 0; i < 3; i++) begin
      decode_ready = 1'b0;
      #1;
      chk_out($sformatf("t2_stall%0d", i), 1'b1, 8'h05, 16'd5);
      chk($sformatf("t2_addr%0d", i), {24'h0, imem_addr}, 32'h05);
      tick;
    end
    decode_ready = 1'b1;
    #1;
    chk_out("t2_rel", 1'b1, 8'h05, 16'd5);
    chk("t2_addr_rel", {24'h0, imem_addr}, 32'h06);
    tick;
    #1;
    chk_out("t2_pc6", 1'b1, 8'h06, 16'd6);
    tick;
    // T3: redirect while pc 7 valid
    #1;
    chk_out("t3_pc7", 1'b1, 8'h07, 16'd7);
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    #1;
    chk_out("t3_sq0", 1'b0, 8'h00, 16'd7);
    tick;
    redirect_valid = 1'b0;
    #1;
    chk_out("t3_sq1", 1'b0, 8'h00, 16'd7);
    chk("t3_addr", {24'h0, imem_addr}, 32'h40);
    tick;
    #1;
    chk_out("t3_tgt", 1'b1, 8'h40, 16'd7);
    // T4: redirect during stall
    decode_ready = 1'b0;
    tick;
    #1;
    chk_out("t4_stall", 1'b1, 8'h40, 16'd7);
    chk("t4_addr_st", {24'h0, imem_addr}, 32'h40);
    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    #1;
    chk_out("t4_sq0", 1'b0, 8'h00, 16'd7);
    chk("t4_addr_rd", {24'h0, imem_addr}, 32'h41);
    tick;
    redirect_valid = 1'b0;
    #1;
    chk_out("t4_sq1", 1'b0, 8'h00, 16'd7);
    chk("t4_addr_tg", {24'h0, imem_addr}, 32'h10);
    tick;
    #1;
    chk_out("t4_tgt", 1'b1, 8'h10, 16'd7);
    decode_ready = 1'b1;
    tick;
    #1;
    chk_out("t4_next", 1'b1, 8'h11, 16'd8);
    // T6: reset mid-stream
    reset = 1'b1;
    tick;
    #1;
    chk_out("t6_rst", 1'b0, 8'h00, 16'd0);
    chk("t6_addr", {24'h0, imem_addr}, 32'h00);
    reset = 1'b0;
    tick;
    #1;
    chk_out("t6_pc0", 1'b1, 8'h00, 16'd0);
    tick;
    #1;
    chk_out("t6_pc1", 1'b1, 8'h01, 16'd1);
    // T5: wrap instance
    reset2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      #1;
      chk($sformatf("t5_v%0d", i), {31'h0, instr_valid2}, 32'h1);
      chk($sformatf("t5_pc%0d", i), {24'h0, instr_pc2},
          {24'h0, 8'(8'hFE + i)});
      chk($sformatf("t5_cnt%0d", i), {28'h0, fetch_count2}, 32'(i));
    end
    for (int i = 0; i < 14; i++) tick;
    #1;
    chk("t5_pc_end", {24'h0, instr_pc2}, 32'h0F);
    chk("t5_instr_end", instr2, 32'hA000_000F);
    chk("t5_cnt_wrap", {28'h0, fetch_count2}, 32'h1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
